mac_result_serializer: RTL and testbench
========================================

// Module: mac_result_serializer
// PURPOSE
//  Reader/drain side of the MAC accumulator. Captures each 16-bit accumulator result plus flags
//  into a small FIFO, then streams it out as a byte frame over an 8-bit valid/ready bus.
//  Sits between the accumulator and the uo_out pins / host read logic.
//  Decouples the accumulator update rate from a slower host.
// PARAMETERS
//  DEPTH        4  FIFO entries; power of two, >= 2.
//  SEND_STATUS  1  1: frame = STATUS, MSB, LSB. 0: frame = MSB, LSB (status byte omitted).
// PORTS
//  clk           in   1   clock, rising edge
//  rst           in   1   asynchronous reset, active-high
//  result_in     in   16  accumulator result_out
//  overflow_in   in   1   accumulator overflow_out
//  acc_msb_in    in   1   accumulator_value[16]
//  result_valid  in   1   1-cycle strobe: result_in/flags updated this cycle
//  clear_drop    in   1   clears sticky dropped flag
//  out_ready     in   1   host accepts data_out this cycle
//  data_out      out  8   current frame byte
//  data_valid    out  1   data_out valid
//  frame_start   out  1   high with the first byte of each frame
//  busy          out  1   FIFO non-empty or frame in progress
//  dropped       out  1   sticky: a result was lost because FIFO was full
//  fifo_count    out  $clog2(DEPTH)+1  occupied entries
// BEHAVIOUR
//  - Reset (async): FIFO empty, pointers 0, seq=0, state IDLE, all outputs 0.
//  - Entry = {overflow_in, acc_msb_in, seq[2:0], result_in[15:0]}, written on the edge ending the
//    result_valid cycle. seq is a 3-bit counter: +1 per accepted push, wraps 7->0.
//  - Push accepted when !full, or when full and the head's last byte transfers that same cycle.
//    Otherwise the result is discarded, seq unchanged, dropped<=1.
//  - dropped stays set until clear_drop. If set and clear coincide, set wins.
//  - FSM states: IDLE, STATUS, MSB, LSB.
//    - IDLE -> STATUS (MSB if SEND_STATUS=0) on any edge where the FIFO is non-empty after the
//      update. This includes the push edge itself, so first byte latency is 1 cycle after
//      result_valid.
//    - STATUS->MSB->LSB, each advance on transfer (data_valid & out_ready).
//    - LSB transfer pops the head; next state is STATUS/MSB if entries remain, else IDLE.
//  - Byte encoding:
//    - STATUS = {ovf, acc_msb, dropped, 2'b00, seq[2:0]}. dropped is the live value.
//    - MSB = result[15:8]; LSB = result[7:0].
//  - data_valid = (state != IDLE). frame_start = data_valid & first-byte state.
//  - While data_valid & !out_ready, data_out and frame_start hold stable. No byte is skipped or
//    repeated.
//  - fifo_count reflects post-edge occupancy. Simultaneous push and pop leaves the count unchanged.
//  - Pointers wrap modulo DEPTH. full = (count==DEPTH); empty = (count==0).
//  - out_ready while IDLE has no effect. result_valid with FIFO empty is forwarded in 1 cycle.
//  - Reset mid-frame aborts the frame; the partial frame is not resumed.
// TESTING
//  1. SEND_STATUS=1, result_valid with 0x1234, ovf=0, out_ready=1:
//     -> bytes 0x00,0x12,0x34 on 3 consecutive cycles starting 1 cycle later; frame_start on byte 1.
//  2. out_ready=0 for 5 cycles mid-frame on MSB:
//     -> data_out holds 0x12, data_valid=1; resumes with 0x34 after ready.
//  3. out_ready=0, push 5 results (DEPTH=4):
//     -> fifo_count=4, dropped=1, drained seq 0..3, status bit5=1.
//     clear_drop -> dropped=0.
//  4. FIFO full, push coincides with LSB transfer:
//     -> push accepted, count stays 4, dropped stays 0.
//  5. 9 pushes drained continuously:
//     -> status seq field 0..7 then 0 (wrap); ovf/acc_msb bits track inputs.
//  6. SEND_STATUS=0 frame 0xBEEF -> 0xBE,0xEF. Assert rst after MSB:
//     -> all outputs 0, count 0, next push starts a fresh frame.

Source files
------------

// File: rtl/mac_result_serializer.sv
// Drain side of the MAC accumulator: buffers results in a small FIFO and
// streams each one out as a STATUS/MSB/LSB byte frame over a valid/ready bus.
module mac_result_serializer #(
    parameter int DEPTH       = 4,
    parameter bit SEND_STATUS = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [15:0]              result_in,
    input  logic                     overflow_in,
    input  logic                     acc_msb_in,
    input  logic                     result_valid,
    input  logic                     clear_drop,
    input  logic                     out_ready,
    output logic [7:0]               data_out,
    output logic                     data_valid,
    output logic                     frame_start,
    output logic                     busy,
    output logic                     dropped,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STATUS = 2'd1;
    localparam logic [1:0] MSB    = 2'd2;
    localparam logic [1:0] LSB    = 2'd3;
    localparam logic [1:0] FIRST  = SEND_STATUS ? STATUS : MSB;

    // entry layout: {ovf, acc_msb, seq[2:0], result[15:0]}
    logic [20:0]   mem [DEPTH];
    logic [20:0]   head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_next;
    logic [2:0]    seq;
    logic [1:0]    state, state_next;
    logic          full, pop, push;

    assign head = mem[rd_ptr];
    assign full = (count == FULL_CNT);
    assign pop  = (state == LSB) && out_ready;
    // A full FIFO still accepts when the head drains on the same edge.
    assign push = result_valid && (!full || pop);
    assign count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (count_next != '0) state_next = FIRST;
            STATUS:  if (out_ready) state_next = MSB;
            MSB:     if (out_ready) state_next = LSB;
            LSB:     if (out_ready) state_next = (count_next != '0) ? FIRST : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            seq     <= 3'd0;
            state   <= IDLE;
            dropped <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                seq    <= seq + 3'd1;
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (result_valid && !push)
                dropped <= 1'b1;
            else if (clear_drop)
                dropped <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {overflow_in, acc_msb_in, seq, result_in};
    end

    // Outputs are decoded from registered state and the FIFO head, so they
    // stay put while the host stalls.
    always_comb begin
        data_out = 8'h00;
        case (state)
            STATUS:  data_out = {head[20], head[19], dropped, 2'b00, head[18:16]};
            MSB:     data_out = head[15:8];
            LSB:     data_out = head[7:0];
            default: data_out = 8'h00;
        endcase
    end

    assign data_valid  = (state != IDLE);
    assign frame_start = (state == FIRST);
    assign busy        = (count != '0) || data_valid;
    assign fifo_count  = count;

endmodule

// File: tb/tb_mac_result_serializer.sv
// Randomized bench: two serializers (with and without status byte) share the
// same stimulus and are compared every cycle against a queue/byte-index model.
module tb_mac_result_serializer;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst;
    logic [15:0] result_in;
    logic overflow_in, acc_msb_in, result_valid, clear_drop, out_ready;

    logic [1:0][7:0]    d_out;
    logic [1:0]         d_vld, f_start, bsy, drp;
    logic [1:0][CW-1:0] f_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mac_result_serializer #(.DEPTH(DEPTH), .SEND_STATUS(1)) dut_s (
        .clk(clk), .rst(rst), .result_in(result_in), .overflow_in(overflow_in),
        .acc_msb_in(acc_msb_in), .result_valid(result_valid), .clear_drop(clear_drop),
        .out_ready(out_ready), .data_out(d_out[0]), .data_valid(d_vld[0]),
        .frame_start(f_start[0]), .busy(bsy[0]), .dropped(drp[0]), .fifo_count(f_cnt[0])
    );

    mac_result_serializer #(.DEPTH(DEPTH), .SEND_STATUS(0)) dut_n (
        .clk(clk), .rst(rst), .result_in(result_in), .overflow_in(overflow_in),
        .acc_msb_in(acc_msb_in), .result_valid(result_valid), .clear_drop(clear_drop),
        .out_ready(out_ready), .data_out(d_out[1]), .data_valid(d_vld[1]),
        .frame_start(f_start[1]), .busy(bsy[1]), .dropped(drp[1]), .fifo_count(f_cnt[1])
    );

    // model: m=0 sends 3-byte frames, m=1 sends 2-byte frames
    logic [20:0] mq [2][DEPTH];
    int          mcnt [2];
    int          midx [2];
    bit          mact [2];
    logic [2:0]  mseq [2];
    bit          mdrop [2];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mcnt[m] = 0; midx[m] = 0; mact[m] = 0; mseq[m] = 3'd0; mdrop[m] = 0;
        end
    endtask

    function automatic logic [7:0] exp_byte(int m);
        logic [20:0] e;
        int k;
        e = mq[m][0];
        k = midx[m] + ((m == 1) ? 1 : 0);
        case (k)
            0:       return {e[20], e[19], mdrop[m], 2'b00, e[18:16]};
            1:       return e[15:8];
            default: return e[7:0];
        endcase
    endfunction

    task automatic check_all();
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("m%0d data_valid", m),  int'(d_vld[m]),   int'(mact[m]));
            chk($sformatf("m%0d data_out", m),    int'(d_out[m]),   mact[m] ? int'(exp_byte(m)) : 0);
            chk($sformatf("m%0d frame_start", m), int'(f_start[m]), int'(mact[m] && midx[m] == 0));
            chk($sformatf("m%0d busy", m),        int'(bsy[m]),     int'(mact[m] || mcnt[m] > 0));
            chk($sformatf("m%0d dropped", m),     int'(drp[m]),     int'(mdrop[m]));
            chk($sformatf("m%0d fifo_count", m),  int'(f_cnt[m]),   mcnt[m]);
        end
    endtask

    // Advance the model by one clock edge using the inputs applied for that edge.
    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            int  nb;
            bit  xfer, pop, acc;
            nb   = (m == 0) ? 3 : 2;
            xfer = mact[m] && out_ready;
            pop  = xfer && (midx[m] == nb - 1);
            acc  = result_valid && (mcnt[m] < DEPTH || pop);
            if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++) mq[m][i] = mq[m][i+1];
                mcnt[m]--;
            end
            if (acc) begin
                mq[m][mcnt[m]] = {overflow_in, acc_msb_in, mseq[m], result_in};
                mcnt[m]++;
                mseq[m] = mseq[m] + 3'd1;
            end
            if (result_valid && !acc) mdrop[m] = 1;
            else if (clear_drop)      mdrop[m] = 0;
            if (mact[m]) begin
                if (pop) begin
                    mact[m] = (mcnt[m] > 0);
                    midx[m] = 0;
                end else if (xfer) begin
                    midx[m]++;
                end
            end else if (mcnt[m] > 0) begin
                mact[m] = 1;
                midx[m] = 0;
            end
        end
    endtask

    task automatic idle_inputs();
        result_in = 16'h0; overflow_in = 0; acc_msb_in = 0;
        result_valid = 0; clear_drop = 0; out_ready = 0;
    endtask

    // per phase: result_valid %, out_ready %, clear_drop %
    int ph_v [7] = '{100, 30, 80, 60, 50, 90, 20};
    int ph_r [7] = '{100, 100, 20, 0, 70, 90, 50};
    int ph_c [7] = '{0, 5, 10, 0, 20, 5, 50};

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        rst = 1'b0;

        for (int p = 0; p < 7; p++) begin
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                check_all();
                result_valid = ($urandom_range(99) < ph_v[p]);
                out_ready    = ($urandom_range(99) < ph_r[p]);
                clear_drop   = ($urandom_range(99) < ph_c[p]);
                result_in    = 16'($urandom);
                overflow_in  = 1'($urandom);
                acc_msb_in   = 1'($urandom);
                @(posedge clk);
                model_step();
            end
            // asynchronous reset, likely mid-frame
            @(negedge clk);
            idle_inputs();
            rst = 1'b1;
            model_reset();
            #1;
            check_all();
            @(negedge clk);
            rst = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
